// File: rtl/ps2kb_pkg.sv
// Shared constants, FSM state and event-word layout for the PS/2 Set 2 scan
// code decoder and its event FIFO.
package ps2kb_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;

   // Keyboard responses and error codes; never keys.
   localparam logic [7:0] SC_ERR0   = 8'h00;
   localparam logic [7:0] SC_BAT_OK = 8'hAA;
   localparam logic [7:0] SC_ECHO   = 8'hEE;
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_RESEND = 8'hFE;
   localparam logic [7:0] SC_ERR1   = 8'hFF;

   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;

   localparam logic [2:0] PAUSE_SWALLOW = 3'd7;

   localparam int EV_CODE_LSB = 0;
   localparam int EV_CODE_MSB = 7;
   localparam int EV_BRK_BIT  = 8;
   localparam int EV_EXT_BIT  = 9;
   localparam int EV_W        = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXTBRK,
      ST_PAUSE
   } state_e;

   typedef struct packed {
      logic lshift;
      logic rshift;
      logic lctrl;
      logic rctrl;
      logic lalt;
      logic ralt;
   } mods_t;

   function automatic logic is_response(input logic [7:0] b);
      return (b == SC_ERR0) || (b == SC_BAT_OK) || (b == SC_ECHO) ||
             (b == SC_ACK) || (b == SC_RESEND) || (b == SC_ERR1);
   endfunction

endpackage

// File: rtl/ps2kb_evt_fifo.sv
// First-word-fall-through event FIFO; a push while full is accepted only when
// a pop frees the head slot in the same cycle.
module ps2kb_evt_fifo
   import ps2kb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_i,
   input  logic [EV_W-1:0] data_i,
   output logic            full_o,
   input  logic            pop_i,
   output logic            empty_o,
   output logic [EV_W-1:0] data_o
);

   localparam int AW = $clog2(DEPTH);

   logic [EV_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW:0]     count_q;
   logic            do_push;
   logic            do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; the head word is
   // masked to zero while empty, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2kb_scan_decoder.sv
// Scan Code Set 2 prefix parser: turns received bytes into {ext, brk, code}
// key events, tracks shift/ctrl/alt and queues events for the system side.
module ps2kb_scan_decoder
   import ps2kb_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_done_tick,
   input  logic [7:0] din,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_brk,
   output logic       shift,
   output logic       ctrl,
   output logic       alt,
   output logic       overflow
);

   localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   state_e          state_q, state_d;
   logic [2:0]      swallow_q, swallow_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   mods_t           mods_q, mods_d;
   logic            ovf_q, ovf_d;

   logic            evt_valid;
   logic            evt_ext;
   logic            evt_brk;
   logic [7:0]      evt_code;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_pop;
   logic [EV_W-1:0] fifo_dout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         swallow_q <= '0;
         tmo_q     <= '0;
         mods_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         swallow_q <= swallow_d;
         tmo_q     <= tmo_d;
         mods_q    <= mods_d;
         ovf_q     <= ovf_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the case statements can infer a latch.
   always_comb begin
      state_d   = state_q;
      swallow_d = swallow_q;
      tmo_d     = '0;
      evt_valid = 1'b0;
      evt_ext   = 1'b0;
      evt_brk   = 1'b0;
      evt_code  = din;

      // A stalled partial sequence is abandoned; an arriving byte wins.
      if (state_q != ST_IDLE && !rx_done_tick) begin
         if (tmo_q == TMO_LAST) state_d = ST_IDLE;
         else                   tmo_d   = tmo_q + TW'(1);
      end

      if (rx_done_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (din == SC_EXT)         state_d = ST_EXT;
               else if (din == SC_BRK)    state_d = ST_BRK;
               else if (din == SC_PAUSE) begin
                  state_d   = ST_PAUSE;
                  swallow_d = PAUSE_SWALLOW;
               end else if (!is_response(din)) evt_valid = 1'b1;
            end
            ST_EXT: begin
               if (din == SC_BRK)        state_d = ST_EXTBRK;
               else if (din != SC_EXT) begin
                  evt_valid = 1'b1;
                  evt_ext   = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            ST_BRK: begin
               evt_valid = 1'b1;
               evt_brk   = 1'b1;
               state_d   = ST_IDLE;
            end
            ST_EXTBRK: begin
               evt_valid = 1'b1;
               evt_ext   = 1'b1;
               evt_brk   = 1'b1;
               state_d   = ST_IDLE;
            end
            ST_PAUSE: begin
               swallow_d = swallow_q - 3'd1;
               if (swallow_q == 3'd1) begin
                  evt_valid = 1'b1;
                  evt_code  = SC_PAUSE;
                  state_d   = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Modifiers follow every decoded event, including ones the FIFO drops.
   always_comb begin
      mods_d = mods_q;
      if (evt_valid) begin
         case (evt_code)
            SC_LSHIFT: if (!evt_ext) mods_d.lshift = ~evt_brk;
            SC_RSHIFT: mods_d.rshift = ~evt_brk;
            SC_CTRL: begin
               if (evt_ext) mods_d.rctrl = ~evt_brk;
               else         mods_d.lctrl = ~evt_brk;
            end
            SC_ALT: begin
               if (evt_ext) mods_d.ralt = ~evt_brk;
               else         mods_d.lalt = ~evt_brk;
            end
            default: ;
         endcase
      end
   end

   assign fifo_pop = ~fifo_empty & ev_ready;
   assign ovf_d    = ovf_q | (evt_valid & fifo_full & ~fifo_pop);

   ps2kb_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (evt_valid),
      .data_i  ({evt_ext, evt_brk, evt_code}),
      .full_o  (fifo_full),
      .pop_i   (fifo_pop),
      .empty_o (fifo_empty),
      .data_o  (fifo_dout)
   );

   assign ev_valid = ~fifo_empty;
   assign ev_code  = fifo_dout[EV_CODE_MSB:EV_CODE_LSB];
   assign ev_brk   = fifo_dout[EV_BRK_BIT];
   assign ev_ext   = fifo_dout[EV_EXT_BIT];
   assign shift    = mods_q.lshift | mods_q.rshift;
   assign ctrl     = mods_q.lctrl | mods_q.rctrl;
   assign alt      = mods_q.lalt | mods_q.ralt;
   assign overflow = ovf_q;

endmodule

// File: doc/ps2kb_scan_decoder.md
# ps2kb_scan_decoder

Downstream consumer of the PS/2 keyboard receiver. Takes each received byte (`rx_done_tick` / `dout` of `ps2kb_rx`) and parses Scan Code Set 2 prefixes (E0 extended, F0 break, E1 pause). Emits one key event per complete sequence into a small FIFO, and tracks the shift/ctrl/alt modifier state. System logic reads events through a valid/ready port.

## Interface
- `DEPTH`, 8: event FIFO entries; power of two, at least 2.
- `TIMEOUT_CYC`, 100000: idle cycles after which a partial sequence is abandoned (2 ms at 50 MHz).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `rx_done_tick`  in  1  one-cycle strobe: `din` holds a new byte.
- `din`  in  8  received byte (connects to `ps2kb_rx.dout`).
- `ev_valid`  out  1  FIFO head holds an event.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_code`  out  8  scan code of the head event.
- `ev_ext`  out  1  head event was E0-prefixed.
- `ev_brk`  out  1  head event is a release (F0).
- `shift`, `ctrl`, `alt`  out  1 each  current modifier state.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- **Reset.**
  - All outputs are 0 during and after reset: `ev_valid`, `ev_code`, `ev_ext`, `ev_brk`, modifiers, `overflow`.
  - FIFO is empty and the FSM is in IDLE.
- **Byte sampling.** A byte is consumed only in a cycle where `rx_done_tick`=1.
- **FSM states:** IDLE, EXT, BRK, EXTBRK, PAUSE.
  - IDLE + E0 → EXT.
  - IDLE + F0 → BRK.
  - IDLE + E1 → PAUSE, with the swallow counter loaded to 7.
  - IDLE + any of 00, AA, EE, FA, FE, FF → dropped, no event, stay in IDLE.
  - IDLE + other byte → make event {ext=0, brk=0}.
  - EXT + F0 → EXTBRK.
  - EXT + E0 → stay in EXT.
  - EXT + other byte → event {ext=1, brk=0} → IDLE.
  - BRK + byte → event {ext=0, brk=1} → IDLE.
  - EXTBRK + byte → event {ext=1, brk=1} → IDLE.
  - PAUSE: each byte decrements the counter. The byte that brings it to 0 emits one event {code=E1, ext=0, brk=0} → IDLE.
- **Timeout.**
  - In any non-IDLE state, a cycle counter is cleared on each byte.
  - When the counter reaches `TIMEOUT_CYC`-1 with no byte, the FSM returns to IDLE and emits nothing.
- **Modifiers.** Updated on every decoded event, even when the FIFO is full.
  - Codes: 12 = lshift, 59 = rshift, 14 = ctrl (left or right per `ev_ext`), 11 = alt (left or right per `ev_ext`).
  - A make event sets the corresponding sub-flag; a break event clears it.
  - Each output is the OR of its left and right flags.
  - `ext` 12 (fake shift emitted around E0 keys) is ignored for modifiers but still queued.
- **FIFO.** First-word-fall-through, storing 10-bit words {ext, brk, code}.
  - Pop occurs when `ev_valid` & `ev_ready`.
  - Push when full with no simultaneous pop: the event is dropped and `overflow` is set. `overflow` clears only on `rst`.
  - Push and pop in the same cycle: both happen, count unchanged, no overflow even when full.
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. A separate count of `$clog2(DEPTH)`+1 bits provides full/empty.

## Timing
- Completing byte at cycle N: the FIFO write happens at the end of N, and `ev_valid`=1 from cycle N+1. The same edge updates the modifiers.
- `ev_*` outputs are stable while `ev_valid`=1 and `ev_ready`=0.
- After a pop at cycle M, the next entry (if any) is presented at M+1.
- No push-to-pop bypass: a push into an empty FIFO cannot be popped in the same cycle.
- Throughput: one byte per cycle sustained; the PS/2 rate is far lower.
- Asynchronous `rst` mid-sequence: the FSM, counters, FIFO and modifiers clear immediately; a partial prefix is lost.

## Structure
- Package `ps2kb_pkg`:
  - byte constants: `SC_EXT`=E0, `SC_BRK`=F0, `SC_PAUSE`=E1, the response/error codes, and the modifier codes;
  - FSM state enum;
  - event word field positions (code [7:0], brk [8], ext [9]).
- Sub-module `ps2kb_evt_fifo`, parameterised by `DEPTH`, with push/full and pop/empty. The parser FSM and modifier registers stay in the top level.

## Test plan
- Bytes 1C; F0 1C → events {1C,0,0} then {1C,0,1}; `ev_valid` rises the cycle after each completing byte.
- Bytes E0 75; E0 F0 75 → {75,1,0}, {75,1,1}. Bytes 12 then 1C → `shift`=1 from the cycle after 12. Then F0 12 → `shift`=0.
- Bytes E1 14 77 E1 F0 14 F0 77 → exactly one event {E1,0,0}. Bytes AA, FA → no event.
- Byte E0 then idle `TIMEOUT_CYC` cycles, then byte 1C → single event {1C,0,0} with ext=0.
- With `ev_ready`=0, send DEPTH+1 make codes → first DEPTH are kept in order and `overflow`=1. Then with the FIFO full, push and pop in the same cycle → count stays DEPTH and the queue stays ordered.
- Assert `rst` between F0 and 1C → no event; after release, byte 1C yields {1C,0,0} (not a break).
